// File: rtl/mem_stage_ws.sv
// MEM stage of the LAPIDO pipeline: byte-addressable data memory with wait states,
// load extension, misalignment detection and the MEM/WB pipeline register.
module mem_stage_ws #(
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_DEPTH      = 1024,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      flush,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [1:0]                mem_size,
  input  logic                      mem_unsigned,
  input  logic [1:0]                wb_res_mux,
  input  logic                      reg_write_enable,
  input  logic                      branch_taken,
  input  logic [PC_WIDTH-1:0]       in_next_pc,
  input  logic [31:0]               alu_res,
  input  logic [31:0]               in_mem_addr,
  input  logic [31:0]               in_mem_data,
  input  logic [31:0]               in_immediate,
  input  logic [REG_ADDR_WIDTH-1:0] in_reg_dst,
  output logic                      stall_out,
  output logic                      out_valid,
  output logic [1:0]                out_wb_res_mux,
  output logic                      out_reg_write_enable,
  output logic                      out_branch_taken,
  output logic [PC_WIDTH-1:0]       out_next_pc,
  output logic [31:0]               out_alu_res,
  output logic [31:0]               out_imm,
  output logic [REG_ADDR_WIDTH-1:0] out_reg_dst,
  output logic [31:0]               out_mem_data,
  output logic                      out_misaligned
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [31:0]   mem [MEM_DEPTH];
  logic [3:0]    cnt_q, cnt_d;
  logic          memop, complete, mis, we;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wdata, wmerge, rword, ld_data;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic          unused_addr;

  assign unused_addr = ^in_mem_addr[31:AW+2];
  assign idx   = in_mem_addr[AW+1:2];
  assign lane  = in_mem_addr[1:0];
  assign memop = in_valid & (mem_read | mem_write);
  // Flush cancels the stall so the killed slot drains in a single cycle.
  assign stall_out = memop & ~flush & (cnt_q != WS);
  assign complete  = memop & ~flush & (cnt_q == WS);
  assign cnt_d     = stall_out ? cnt_q + 4'd1 : 4'd0;

  always_comb begin
    mis   = 1'b0;
    be    = 4'b1111;
    wdata = in_mem_data;
    case (mem_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{in_mem_data[7:0]}};
      end
      2'b01: begin
        mis   = lane[0];
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{in_mem_data[15:0]}};
      end
      default: mis = (lane != 2'b00);
    endcase
  end

  // Read wins when both read and write are requested.
  assign we    = complete & mem_write & ~mem_read & ~mis;
  assign rword = mem[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    for (int b = 0; b < 4; b++)
      wmerge[8*b +: 8] = be[b] ? wdata[8*b +: 8] : rword[8*b +: 8];
  end

  always_comb begin
    case (mem_size)
      2'b00:   ld_data = {{24{~mem_unsigned & rbyte[7]}}, rbyte};
      2'b01:   ld_data = {{16{~mem_unsigned & rhalf[15]}}, rhalf};
      default: ld_data = rword;
    endcase
    if (mis) ld_data = '0;
  end

  // Storage is not reset; a write is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && we) mem[idx] <= wmerge;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= flush ? 4'd0 : cnt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid            <= 1'b0;
      out_wb_res_mux       <= '0;
      out_reg_write_enable <= 1'b0;
      out_branch_taken     <= 1'b0;
      out_next_pc          <= '0;
      out_alu_res          <= '0;
      out_imm              <= '0;
      out_reg_dst          <= '0;
      out_mem_data         <= '0;
      out_misaligned       <= 1'b0;
    end else if (flush || stall_out) begin
      out_valid            <= 1'b0;
      out_reg_write_enable <= 1'b0;
    end else begin
      out_valid            <= in_valid;
      out_wb_res_mux       <= wb_res_mux;
      out_reg_write_enable <= reg_write_enable;
      out_branch_taken     <= branch_taken;
      out_next_pc          <= in_next_pc;
      out_alu_res          <= alu_res;
      out_imm              <= in_immediate;
      out_reg_dst          <= in_reg_dst;
      out_mem_data         <= (memop && mem_read) ? ld_data : 32'd0;
      out_misaligned       <= memop & mis;
    end
  end
endmodule
